// File: rtl/apb_pixel_slave_if.sv
// rtl/apb_pixel_slave_if.sv - APB bus bundle between host and pixel slave
interface apb_pixel_slave_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_pixel_slave.sv
// rtl/apb_pixel_slave.sv - APB config registers plus pixel FIFO feeding the watermark core
// Optional macro APB_RANGE_CHECK_EN: out-of-range or dropped writes answer with PSLVERR.
module apb_pixel_slave #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  apb_pixel_slave_if.slave apb,
  output logic             start,
  output logic [7:0]       white_pixel,
  output logic [9:0]       ImgSize,
  output logic [9:0]       WmSize,
  output logic [6:0]       M,
  output logic [4:0]       Bthr,
  output logic [6:0]       Amin,
  output logic [6:0]       Amax,
  output logic [5:0]       Bmin,
  output logic [5:0]       Bmax,
  output logic             new_pixel,
  output logic [7:0]       Pixel_Data,
  input  logic             pixel_ready,
  output logic             Image_Done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  state_t      r_state;
  logic        r_start;
  logic [7:0]  r_white;
  logic [9:0]  r_img;
  logic [9:0]  r_wm;
  logic [6:0]  r_m;
  logic [4:0]  r_bthr;
  logic [6:0]  r_amin;
  logic [6:0]  r_amax;
  logic [5:0]  r_bmin;
  logic [5:0]  r_bmax;
  logic [20:0] r_total;
  logic [20:0] r_delivered;
  logic        r_done;
  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;

  logic        w_access;
  logic        w_low_addr;
  logic        w_ready;
  logic        w_wr;
  logic        w_val_ok;
  logic        w_cfg_wr;
  logic        w_start_wr;
  logic        w_flush;
  logic        w_pix_in_map;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic [31:0] w_pix_off;
  logic [31:0] w_rdata;
  logic [20:0] w_img21;
  logic [20:0] w_wm21;
  logic [20:0] w_total_calc;
  logic [20:0] w_deliv_next;

  assign w_access   = apb.PSEL & apb.PENABLE;
  assign w_low_addr = apb.PADDR < 32'd10;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  // Stall only pixel writes against a full FIFO; a same-cycle pop does not release it.
  assign w_ready     = ~(w_access & apb.PWRITE & ~w_low_addr & w_full);
  assign apb.PREADY  = w_ready;
  assign w_wr        = w_access & apb.PWRITE & w_ready;

`ifdef APB_RANGE_CHECK_EN
  always_comb begin
    w_val_ok = 1'b0;
    case (apb.PADDR[3:0])
      4'd0:       w_val_ok = apb.PWDATA <= 32'd1;
      4'd1:       w_val_ok = (apb.PWDATA >= 32'd1)  && (apb.PWDATA <= 32'd255);
      4'd2, 4'd3: w_val_ok = (apb.PWDATA >= 32'd200) && (apb.PWDATA <= 32'd720);
      4'd4:       w_val_ok = (apb.PWDATA >= 32'd1)  && (apb.PWDATA <= 32'd72);
      4'd5:       w_val_ok = (apb.PWDATA >= 32'd1)  && (apb.PWDATA <= 32'd20);
      4'd6:       w_val_ok = (apb.PWDATA >= 32'd80) && (apb.PWDATA <= {25'd0, r_amax});
      4'd7:       w_val_ok = (apb.PWDATA >= 32'd90) && (apb.PWDATA <= 32'd99);
      4'd8:       w_val_ok = (apb.PWDATA >= 32'd20) && (apb.PWDATA <= {26'd0, r_bmax});
      4'd9:       w_val_ok = (apb.PWDATA >= 32'd30) && (apb.PWDATA <= 32'd40);
      default:    w_val_ok = 1'b0;
    endcase
  end
`else
  assign w_val_ok = 1'b1;
`endif

  // Only the start bit stays writable once a frame is underway.
  assign w_cfg_wr   = w_wr & w_low_addr & w_val_ok &
                      ((r_state == S_IDLE) || (apb.PADDR[3:0] == 4'd0));
  assign w_start_wr = w_cfg_wr & (apb.PADDR[3:0] == 4'd0) & apb.PWDATA[0];
  assign w_flush    = w_cfg_wr & (apb.PADDR[3:0] == 4'd0) & ~apb.PWDATA[0];

  assign w_pix_off    = apb.PADDR - 32'd10;
  assign w_pix_in_map = ~w_low_addr & (w_pix_off < {11'd0, r_total});
  assign w_push       = w_wr & w_pix_in_map & (r_state == S_STREAM);
  assign w_pop        = ~w_empty & pixel_ready;

`ifdef APB_RANGE_CHECK_EN
  assign apb.PSLVERR = w_wr & ~w_cfg_wr & ~w_push;
`else
  assign apb.PSLVERR = 1'b0;
`endif

  always_comb begin
    w_rdata = '0;
    case (apb.PADDR[3:0])
      4'd0:    w_rdata = {31'd0, r_start};
      4'd1:    w_rdata = {24'd0, r_white};
      4'd2:    w_rdata = {22'd0, r_img};
      4'd3:    w_rdata = {22'd0, r_wm};
      4'd4:    w_rdata = {25'd0, r_m};
      4'd5:    w_rdata = {27'd0, r_bthr};
      4'd6:    w_rdata = {25'd0, r_amin};
      4'd7:    w_rdata = {25'd0, r_amax};
      4'd8:    w_rdata = {26'd0, r_bmin};
      4'd9:    w_rdata = {26'd0, r_bmax};
      default: w_rdata = '0;
    endcase
  end

  assign apb.PRDATA = (w_access & ~apb.PWRITE & w_low_addr) ? w_rdata : 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start <= 1'b0;
      r_white <= '0;
      r_img   <= '0;
      r_wm    <= '0;
      r_m     <= '0;
      r_bthr  <= '0;
      r_amin  <= '0;
      r_amax  <= '0;
      r_bmin  <= '0;
      r_bmax  <= '0;
    end else if (w_cfg_wr) begin
      case (apb.PADDR[3:0])
        4'd0:    r_start <= apb.PWDATA[0];
        4'd1:    r_white <= apb.PWDATA[7:0];
        4'd2:    r_img   <= apb.PWDATA[9:0];
        4'd3:    r_wm    <= apb.PWDATA[9:0];
        4'd4:    r_m     <= apb.PWDATA[6:0];
        4'd5:    r_bthr  <= apb.PWDATA[4:0];
        4'd6:    r_amin  <= apb.PWDATA[6:0];
        4'd7:    r_amax  <= apb.PWDATA[6:0];
        4'd8:    r_bmin  <= apb.PWDATA[5:0];
        4'd9:    r_bmax  <= apb.PWDATA[5:0];
        default: ;
      endcase
    end
  end

  assign w_img21      = {11'd0, r_img};
  assign w_wm21       = {11'd0, r_wm};
  assign w_total_calc = w_img21 * w_img21 + w_wm21 * w_wm21;
  assign w_deliv_next = r_delivered + {20'd0, w_pop};

  // Image_Done rises on the same edge as the final pop so it is visible the cycle after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_total     <= '0;
      r_delivered <= '0;
      r_done      <= 1'b0;
    end else if (w_flush) begin
      r_state     <= S_IDLE;
      r_total     <= '0;
      r_delivered <= '0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_wr) begin
            r_total     <= w_total_calc;
            r_delivered <= '0;
            r_state     <= S_STREAM;
          end
        end
        S_STREAM: begin
          r_delivered <= w_deliv_next;
          if (w_deliv_next == r_total) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_delivered <= w_deliv_next;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (w_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= apb.PWDATA[7:0];
  end

  assign start       = r_start;
  assign white_pixel = r_white;
  assign ImgSize     = r_img;
  assign WmSize      = r_wm;
  assign M           = r_m;
  assign Bthr        = r_bthr;
  assign Amin        = r_amin;
  assign Amax        = r_amax;
  assign Bmin        = r_bmin;
  assign Bmax        = r_bmax;
  assign new_pixel   = ~w_empty;
  assign Pixel_Data  = w_empty ? 8'd0 : r_mem[r_rptr[AW-1:0]];
  assign Image_Done  = r_done;
endmodule

// File: tb/tb_apb_pixel_slave.sv
// tb/tb_apb_pixel_slave.sv - directed self-checking bench for apb_pixel_slave
module tb_apb_pixel_slave;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  apb_pixel_slave_if bus();

  logic       start;
  logic [7:0] white_pixel;
  logic [9:0] ImgSize;
  logic [9:0] WmSize;
  logic [6:0] M;
  logic [4:0] Bthr;
  logic [6:0] Amin;
  logic [6:0] Amax;
  logic [5:0] Bmin;
  logic [5:0] Bmax;
  logic       new_pixel;
  logic [7:0] Pixel_Data;
  logic       pixel_ready;
  logic       Image_Done;

  apb_pixel_slave #(.FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .apb         (bus),
    .start       (start),
    .white_pixel (white_pixel),
    .ImgSize     (ImgSize),
    .WmSize      (WmSize),
    .M           (M),
    .Bthr        (Bthr),
    .Amin        (Amin),
    .Amax        (Amax),
    .Bmin        (Bmin),
    .Bmax        (Bmax),
    .new_pixel   (new_pixel),
    .Pixel_Data  (Pixel_Data),
    .pixel_ready (pixel_ready),
    .Image_Done  (Image_Done)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic       mon_en   = 1'b0;
  logic [7:0] got_q [$];
  logic       err;
  logic [31:0] rd;

  always @(negedge clk) begin
    if (mon_en && new_pixel && pixel_ready) got_q.push_back(Pixel_Data);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pix_val(input int i);
    logic [31:0] v;
    v = i * 37 + 5;
    return v[7:0];
  endfunction

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output logic e);
    int n;
    n = 0;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
    bus.PADDR = a;   bus.PWDATA = d;
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    @(negedge clk);
    while (!bus.PREADY && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("pready_wait", {31'd0, bus.PREADY}, 32'd1);
    e = bus.PSLVERR;
    @(posedge clk); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = a;
    @(negedge clk);
    check("prdata_setup_zero", bus.PRDATA, 32'd0);
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    @(negedge clk);
    d = bus.PRDATA;
    @(posedge clk); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    bus.PADDR = '0;  bus.PWDATA = '0;
    pixel_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_start",      {31'd0, start}, 32'd0);
    check("rst_imgsize",    {22'd0, ImgSize}, 32'd0);
    check("rst_new_pixel",  {31'd0, new_pixel}, 32'd0);
    check("rst_pixel_data", {24'd0, Pixel_Data}, 32'd0);
    check("rst_image_done", {31'd0, Image_Done}, 32'd0);
    check("rst_pready",     {31'd0, bus.PREADY}, 32'd1);
    check("rst_pslverr",    {31'd0, bus.PSLVERR}, 32'd0);
    check("rst_prdata",     bus.PRDATA, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Configuration and readback
    apb_write(32'd1, 32'h1AB, err);
    check("white_trunc", {24'd0, white_pixel}, 32'hAB);
    apb_write(32'd4, 32'd72, err);
    check("m_value", {25'd0, M}, 32'd72);
    apb_read(32'd4, rd);
    check("read_addr4", rd, 32'd72);
    apb_read(32'd12, rd);
    check("read_addr12", rd, 32'd0);
    apb_read(32'd1, rd);
    check("read_addr1", rd, 32'hAB);

`ifdef APB_RANGE_CHECK_EN
    apb_write(32'd7, 32'd100, err);
    check("amax100_err", {31'd0, err}, 32'd1);
    check("amax100_keep", {25'd0, Amax}, 32'd0);
`else
    apb_write(32'd7, 32'd100, err);
    check("amax100_err", {31'd0, err}, 32'd0);
    check("amax100_load", {25'd0, Amax}, 32'd100);
`endif
    apb_write(32'd7, 32'd95, err);
    check("amax95_err", {31'd0, err}, 32'd0);
    check("amax95_load", {25'd0, Amax}, 32'd95);

    // Frame of 3*3 + 2*2 = 13 pixels at addresses 10..22
    apb_write(32'd2, 32'd3, err);
    apb_write(32'd3, 32'd2, err);
    check("imgsize", {22'd0, ImgSize}, 32'd3);
    check("wmsize",  {22'd0, WmSize}, 32'd2);
    apb_write(32'd0, 32'd1, err);
    check("start_set", {31'd0, start}, 32'd1);
    apb_write(32'd5, 32'd7, err);
    check("frozen_bthr", {27'd0, Bthr}, 32'd0);
    apb_write(32'd23, 32'h99, err);
    check("oor_pix_pslverr", {31'd0, err}, 32'd0);
    @(negedge clk);
    check("oor_pix_dropped", {31'd0, new_pixel}, 32'd0);

    pixel_ready = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      apb_write(32'(10 + i), {24'd0, pix_val(i)}, err);
      if (i == 0) begin
        @(negedge clk);
        check("first_latency", {31'd0, new_pixel}, 32'd1);
        check("first_data", {24'd0, Pixel_Data}, {24'd0, pix_val(0)});
      end
    end
    @(negedge clk);
    check("last_valid", {31'd0, new_pixel}, 32'd1);
    check("done_not_yet", {31'd0, Image_Done}, 32'd0);
    @(negedge clk);
    check("done_after_pop", {31'd0, Image_Done}, 32'd1);
    check("empty_after_pop", {31'd0, new_pixel}, 32'd0);
    @(negedge clk);
    check("done_held", {31'd0, Image_Done}, 32'd1);
    mon_en = 1'b0;
    check("beat_count", got_q.size(), 32'd13);
    for (int i = 0; i < 13 && i < got_q.size(); i++)
      check($sformatf("beat_%0d", i), {24'd0, got_q[i]}, {24'd0, pix_val(i)});

    @(posedge clk); #1;
    apb_write(32'd0, 32'd0, err);
    @(negedge clk);
    check("done_cleared", {31'd0, Image_Done}, 32'd0);

    // Back-pressure: fifth write stalls on a full 4-deep FIFO
    pixel_ready = 1'b0;
    @(posedge clk); #1;
    apb_write(32'd0, 32'd1, err);
    for (int i = 0; i < 4; i++) apb_write(32'(10 + i), 32'(8'hA0 + i), err);
    @(negedge clk);
    check("full_valid", {31'd0, new_pixel}, 32'd1);
    check("full_head", {24'd0, Pixel_Data}, 32'hA0);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
    bus.PADDR = 32'd14; bus.PWDATA = 32'hA4;
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    @(negedge clk);
    check("stall_pready", {31'd0, bus.PREADY}, 32'd0);
    @(negedge clk);
    check("stall_hold", {31'd0, bus.PREADY}, 32'd0);
    #1 pixel_ready = 1'b1;
    @(posedge clk); #1;
    pixel_ready = 1'b0;
    @(negedge clk);
    check("stall_release", {31'd0, bus.PREADY}, 32'd1);
    check("head_after_pop", {24'd0, Pixel_Data}, 32'hA1);
    @(posedge clk); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    pixel_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check($sformatf("drain_%0d", i), {24'd0, Pixel_Data}, 32'(8'hA0 + i));
    end
    @(posedge clk); #1;
    pixel_ready = 1'b0;
    @(negedge clk);
    check("drained_empty", {31'd0, new_pixel}, 32'd0);

    // Abort mid-stream with three pixels buffered
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) apb_write(32'(15 + i), 32'(8'hC0 + i), err);
    @(negedge clk);
    check("abort_buffered", {31'd0, new_pixel}, 32'd1);
    @(posedge clk); #1;
    apb_write(32'd0, 32'd0, err);
    @(negedge clk);
    check("abort_flush", {31'd0, new_pixel}, 32'd0);
    check("abort_done", {31'd0, Image_Done}, 32'd0);
    check("abort_start", {31'd0, start}, 32'd0);
    @(posedge clk); #1;
    apb_write(32'd5, 32'd9, err);
    check("idle_bthr", {27'd0, Bthr}, 32'd9);
    apb_write(32'd10, 32'h77, err);
    @(negedge clk);
    check("idle_pix_drop", {31'd0, new_pixel}, 32'd0);

    // Asynchronous reset in the middle of a cycle
    @(posedge clk); #1;
    apb_write(32'd0, 32'd1, err);
    apb_write(32'd10, 32'h11, err);
    apb_write(32'd11, 32'h22, err);
    @(negedge clk);
    check("pre_rst_valid", {31'd0, new_pixel}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_new_pixel", {31'd0, new_pixel}, 32'd0);
    check("arst_pixel_data", {24'd0, Pixel_Data}, 32'd0);
    check("arst_white", {24'd0, white_pixel}, 32'd0);
    check("arst_start", {31'd0, start}, 32'd0);
    check("arst_pready", {31'd0, bus.PREADY}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_empty", {31'd0, new_pixel}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/apb_pixel_slave.md
APB_PIXEL_SLAVE -- requirements
Module: apb_pixel_slave

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, pixel buffer depth (power of 2, >=2).
REQ-002 Ports, name  direction  width  meaning:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1=write, 0=read.
- PADDR  in  32  word address.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  transfer error.
- start  out  1  addr 0 bit 0.
- white_pixel  out  8  addr 1.
- ImgSize  out  10  addr 2, host image side.
- WmSize  out  10  addr 3, watermark side.
- M  out  7  addr 4.
- Bthr  out  5  addr 5.
- Amin, Amax  out  7 each  addr 6, 7.
- Bmin, Bmax  out  6 each  addr 8, 9.
- new_pixel  out  1  pixel valid to core.
- Pixel_Data  out  8  pixel value.
- pixel_ready  in  1  core accepts pixel.
- Image_Done  out  1  all pixels delivered.

Function
REQ-003 A transfer SHALL complete on the edge where PSEL&PENABLE&PREADY=1; only completed writes update state.
REQ-004 PREADY SHALL be combinational: 0 only during access phase of a pixel write (PADDR>=10) while the FIFO is full, else 1.
REQ-005 Config writes (addr 0-9) SHALL load PWDATA low bits into the register on the completing edge; zero wait states.
REQ-006 Reads SHALL return the zero-extended register on PRDATA during access phase; addr>=10 and unmapped reads return 0; PRDATA=0 outside access.
REQ-007 FSM states IDLE, STREAM, DONE; IDLE->STREAM on write start=1; STREAM->DONE when delivered count equals TOTAL; any state->IDLE on write start=0.
REQ-008 TOTAL SHALL be ImgSize*ImgSize + WmSize*WmSize, 21-bit unsigned, latched on IDLE->STREAM.
REQ-009 Pixel write (10<=PADDR<=9+TOTAL) in STREAM SHALL push PWDATA[7:0] into FIFO; otherwise it is dropped.
REQ-010 Config writes other than addr 0 in STREAM/DONE SHALL be dropped (registers frozen).
REQ-011 new_pixel SHALL equal FIFO-not-empty; Pixel_Data = FIFO head; pop when new_pixel&pixel_ready.
REQ-012 Simultaneous push and pop on a full FIFO SHALL still stall (PREADY=0); on non-full, both occur, occupancy unchanged.
REQ-013 First pixel write SHALL show new_pixel=1 on the cycle after the completing edge (latency 1).
REQ-014 Delivered counter SHALL increment per pop; Image_Done=1 in DONE only, registered, held until start=0 write or rst.
REQ-015 Write start=0 SHALL flush FIFO and clear counters in the same edge.

Reset
REQ-016 On rst: all registers, PRDATA, PSLVERR, new_pixel, Pixel_Data, Image_Done, counters = 0; FIFO empty; state IDLE; PREADY=1.
REQ-017 rst mid-stream SHALL discard FIFO contents immediately (asynchronous).

Configuration
REQ-018 Macro APB_RANGE_CHECK_EN: when defined, out-of-range writes SHALL set PSLVERR=1 during access phase and leave the register unchanged; ranges: addr0 {0,1}, addr1 1-255, addr2/3 200-720, addr4 1-72, addr5 1-20, addr6 80-Amax, addr7 90-99, addr8 20-Bmax, addr9 30-40, dropped pixel writes (REQ-009/010) also error.
REQ-019 Without APB_RANGE_CHECK_EN: PSLVERR tied 0; all in-map writes load truncated PWDATA per REQ-005.

Verification
REQ-020 rst pulse mid-cycle (async) -> outputs 0, PREADY=1, FIFO empty before next edge.
REQ-021 Write addr2=200, addr3=200, addr0=1, then 80000 pixel writes with pixel_ready=1 -> 80000 new_pixel beats, data in order, Image_Done=1 one cycle after last pop.
REQ-022 pixel_ready=0, 5 pixel writes, FIFO_DEPTH=4 -> fifth write PREADY=0 until pixel_ready=1 for one cycle.
REQ-023 With APB_RANGE_CHECK_EN, write addr7=100 -> PSLVERR=1, Amax unchanged; addr7=95 -> PSLVERR=0, Amax=95.
REQ-024 In STREAM, write addr0=0 with 3 pixels buffered -> new_pixel=0 next cycle, state IDLE, Image_Done=0.
REQ-025 Read addr4 after writing 72 -> PRDATA=72 in access phase; read addr12 -> 0.
